// File: rtl/ssp_cmd_master.sv
// Command-queued SSP register-port master: a small command FIFO feeding a
// frame sequencer that drives an SSP slave and returns one response per command.
module ssp_cmd_master #(
    parameter int CMD_DEPTH    = 4,
    parameter int SETUP_CYC    = 2,
    parameter int POLL_TIMEOUT = 1023
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Cmd_Valid,
    output logic        Cmd_Ready,
    input  logic [1:0]  Cmd_Op,
    input  logic [2:0]  Cmd_RA,
    input  logic [11:0] Cmd_Data,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [11:0] Rsp_Data,
    output logic        Rsp_Err,
    output logic        SSP_SSEL,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic        SSP_EOC,
    output logic [11:0] SSP_DI,
    input  logic [11:0] SSP_DO,
    output logic        Busy
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, RESP} state_t;

    logic [16:0]   mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          push_s;
    logic          pop_s;
    logic [16:0]   head_s;
    logic          poll_match_s;

    state_t        state_r;
    logic [1:0]    op_r;
    logic [11:0]   data_r;
    logic [SW-1:0] setup_cnt_r;
    logic [9:0]    poll_cnt_r;

    assign head_s       = mem[rd_ptr_r];
    assign poll_match_s = ((SSP_DO & data_r) == data_r);

    // FIFO handshake decode and next occupancy
    always_comb begin
        push_s       = Cmd_Valid & Cmd_Ready;
        pop_s        = (state_r == IDLE) && (count_r != '0);
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + (AW+1)'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - (AW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards every read
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= {Cmd_Op, Cmd_RA, Cmd_Data};
        end
    end

    // FIFO pointers, occupancy and the registered ready flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            Cmd_Ready <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r   <= count_next_s;
            Cmd_Ready <= (count_next_s != (AW+1)'(CMD_DEPTH));
        end
    end

    // Frame sequencer with registered SSP and response outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= IDLE;
            op_r        <= 2'd0;
            data_r      <= 12'd0;
            setup_cnt_r <= '0;
            poll_cnt_r  <= 10'd0;
            SSP_SSEL    <= 1'b0;
            SSP_RA      <= 3'd0;
            SSP_WnR     <= 1'b0;
            SSP_EOC     <= 1'b0;
            SSP_DI      <= 12'd0;
            Rsp_Valid   <= 1'b0;
            Rsp_Data    <= 12'd0;
            Rsp_Err     <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            Busy <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        op_r        <= head_s[16:15];
                        data_r      <= head_s[11:0];
                        setup_cnt_r <= '0;
                        poll_cnt_r  <= 10'd0;
                        if (head_s[16:15] == 2'b11) begin
                            state_r   <= RESP;
                            Rsp_Valid <= 1'b1;
                            Rsp_Data  <= 12'd0;
                            Rsp_Err   <= 1'b1;
                        end else begin
                            state_r  <= SETUP;
                            SSP_SSEL <= 1'b1;
                            SSP_RA   <= head_s[14:12];
                            SSP_WnR  <= (head_s[16:15] == 2'b00);
                            SSP_DI   <= (head_s[16:15] == 2'b00) ? head_s[11:0] : 12'd0;
                        end
                    end else begin
                        Busy <= (count_next_s != '0);
                    end
                end
                SETUP: begin
                    if (setup_cnt_r == SW'(SETUP_CYC - 1)) begin
                        state_r     <= STROBE;
                        SSP_EOC     <= 1'b1;
                        setup_cnt_r <= '0;
                    end else begin
                        setup_cnt_r <= setup_cnt_r + SW'(1);
                    end
                end
                STROBE: begin
                    SSP_EOC  <= 1'b0;
                    SSP_SSEL <= 1'b0;
                    case (op_r)
                        2'b00: begin
                            state_r   <= RESP;
                            Rsp_Valid <= 1'b1;
                            Rsp_Data  <= data_r;
                            Rsp_Err   <= 1'b0;
                        end
                        2'b01: begin
                            state_r   <= RESP;
                            Rsp_Valid <= 1'b1;
                            Rsp_Data  <= SSP_DO;
                            Rsp_Err   <= 1'b0;
                        end
                        2'b10: begin
                            if (poll_match_s || (poll_cnt_r == 10'(POLL_TIMEOUT))) begin
                                state_r   <= RESP;
                                Rsp_Valid <= 1'b1;
                                Rsp_Data  <= SSP_DO;
                                Rsp_Err   <= ~poll_match_s;
                            end else begin
                                state_r    <= GAP;
                                poll_cnt_r <= poll_cnt_r + 10'd1;
                            end
                        end
                        default: begin
                            state_r   <= RESP;
                            Rsp_Valid <= 1'b1;
                            Rsp_Data  <= 12'd0;
                            Rsp_Err   <= 1'b1;
                        end
                    endcase
                end
                GAP: begin
                    state_r  <= SETUP;
                    SSP_SSEL <= 1'b1;
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        state_r   <= IDLE;
                        Rsp_Valid <= 1'b0;
                        Rsp_Data  <= 12'd0;
                        Rsp_Err   <= 1'b0;
                        Busy      <= (count_next_s != '0);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ssp_cmd_master.sv
// Self-checking bench for ssp_cmd_master: directed timing checks plus a
// randomized run scored against a command/response queue model.
module tb_ssp_cmd_master;
    localparam int PT = 3;
    localparam int N_RAND = 60;

    logic        Clk;
    logic        Rst;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [1:0]  Cmd_Op;
    logic [2:0]  Cmd_RA;
    logic [11:0] Cmd_Data;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [11:0] Rsp_Data;
    logic        Rsp_Err;
    logic        SSP_SSEL;
    logic [2:0]  SSP_RA;
    logic        SSP_WnR;
    logic        SSP_EOC;
    logic [11:0] SSP_DI;
    logic [11:0] SSP_DO;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  ra;
        logic [11:0] data;
    } cmd_t;
    typedef struct packed {
        logic [11:0] d;
        logic        e;
    } rsp_t;

    cmd_t cq[$];
    rsp_t rq[$];

    ssp_cmd_master #(.CMD_DEPTH(4), .SETUP_CYC(2), .POLL_TIMEOUT(PT)) dut (
        .Clk(Clk), .Rst(Rst),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
        .Cmd_RA(Cmd_RA), .Cmd_Data(Cmd_Data),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
        .Rsp_Err(Rsp_Err),
        .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
        .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: commands in acceptance order, outcome decided at each EOC
    initial begin : monitor
        int   attempts;
        logic prev_eoc;
        logic resolved;
        logic have_exp;
        cmd_t cur;
        rsp_t r;
        attempts = 0;
        prev_eoc = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                cq.delete();
                rq.delete();
                attempts = 0;
                prev_eoc = 1'b0;
            end else begin
                if (prev_eoc) check("ssel_gap", 32'(SSP_SSEL), 32'd0);
                if (SSP_EOC) begin
                    check("eoc_ssel", 32'(SSP_SSEL), 32'd1);
                    if (cq.size() == 0) begin
                        check("eoc_cmd", 32'(cq.size()), 32'd1);
                    end else begin
                        cur = cq[0];
                        check("frame_ra", 32'(SSP_RA), 32'(cur.ra));
                        check("frame_wnr", 32'(SSP_WnR), 32'(cur.op == 2'b00));
                        check("frame_di", 32'(SSP_DI), (cur.op == 2'b00) ? 32'(cur.data) : 32'd0);
                        resolved = 1'b0;
                        r = '0;
                        if (cur.op == 2'b00) begin
                            r.d = cur.data; r.e = 1'b0; resolved = 1'b1;
                        end else if (cur.op == 2'b01) begin
                            r.d = SSP_DO; r.e = 1'b0; resolved = 1'b1;
                        end else if ((SSP_DO & cur.data) == cur.data) begin
                            r.d = SSP_DO; r.e = 1'b0; resolved = 1'b1;
                        end else if (attempts == PT) begin
                            r.d = SSP_DO; r.e = 1'b1; resolved = 1'b1;
                        end else begin
                            attempts++;
                        end
                        if (resolved) begin
                            rq.push_back(r);
                            void'(cq.pop_front());
                            attempts = 0;
                        end
                    end
                end
                if (Rsp_Valid && Rsp_Ready) begin
                    rsp_cnt++;
                    have_exp = 1'b0;
                    r = '0;
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        have_exp = 1'b1;
                    end else if (cq.size() > 0 && cq[0].op == 2'b11) begin
                        r.d = 12'd0; r.e = 1'b1;
                        void'(cq.pop_front());
                        have_exp = 1'b1;
                    end
                    if (!have_exp) begin
                        check("rsp_spurious", 32'(Rsp_Valid), 32'd0);
                    end else begin
                        check("rsp_data", 32'(Rsp_Data), 32'(r.d));
                        check("rsp_err", 32'(Rsp_Err), 32'(r.e));
                    end
                end
                if (Cmd_Valid && Cmd_Ready) cq.push_back({Cmd_Op, Cmd_RA, Cmd_Data});
                prev_eoc = SSP_EOC;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [2:0] ra, input logic [11:0] d);
        logic rdy;
        logic ok;
        ok = 1'b0;
        Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_RA = ra; Cmd_Data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = Cmd_Ready;
            step();
            ok = rdy;
        end
        Cmd_Valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic consume();
        Rsp_Ready = 1'b1;
        step();
        Rsp_Ready = 1'b0;
        check("rsp_drop", 32'(Rsp_Valid), 32'd0);
    endtask

    // Cycle-exact frame timing for one write or read from an idle block
    task automatic lat_test(input logic [1:0] op, input logic [2:0] ra, input logic [11:0] d,
                            input logic [11:0] dov, input logic [11:0] exp_d);
        Rsp_Ready = 1'b0;
        push_cmd(op, ra, d);
        for (int k = 1; k <= 6; k++) begin
            SSP_DO = (k == 4) ? dov : 12'($urandom);
            check("lat_ssel", 32'(SSP_SSEL), 32'(k >= 2 && k <= 4));
            check("lat_eoc", 32'(SSP_EOC), 32'(k == 4));
            check("lat_rsp_valid", 32'(Rsp_Valid), 32'(k >= 5));
            if (k == 3) begin
                check("lat_ra", 32'(SSP_RA), 32'(ra));
                check("lat_wnr", 32'(SSP_WnR), 32'(op == 2'b00));
                check("lat_di", 32'(SSP_DI), (op == 2'b00) ? 32'(d) : 32'd0);
            end
            if (k == 5) begin
                check("lat_data", 32'(Rsp_Data), 32'(exp_d));
                check("lat_err", 32'(Rsp_Err), 32'd0);
            end
            step();
        end
        consume();
    endtask

    // Poll with DO matching only at attempt match_at (0 = never)
    task automatic poll_test(input logic [11:0] mask, input int match_at,
                             input int exp_eocs, input logic exp_err);
        int          eocs;
        int          low_run;
        logic        seen_ssel;
        logic        done;
        logic [11:0] last_do;
        eocs = 0; low_run = 0; seen_ssel = 1'b0; done = 1'b0; last_do = 12'd0;
        Rsp_Ready = 1'b0;
        push_cmd(2'b10, 3'd1, mask);
        for (int c = 0; c < 300 && !done; c++) begin
            if (SSP_EOC) begin
                eocs++;
                last_do = (eocs == match_at) ? (12'($urandom) | mask) : (12'($urandom) & ~mask);
                SSP_DO = last_do;
            end else begin
                SSP_DO = 12'($urandom);
            end
            if (SSP_SSEL) begin
                if (seen_ssel && low_run > 0) check("poll_gap", 32'(low_run), 32'd1);
                seen_ssel = 1'b1;
                low_run = 0;
            end else if (seen_ssel) begin
                low_run++;
            end
            if (Rsp_Valid) done = 1'b1;
            else step();
        end
        check("poll_done", 32'(done), 32'd1);
        check("poll_eocs", 32'(eocs), 32'(exp_eocs));
        check("poll_err", 32'(Rsp_Err), 32'(exp_err));
        check("poll_data", 32'(Rsp_Data), 32'(last_do));
        consume();
    endtask

    initial begin : main
        logic        rdy;
        int          acc6;
        int          eocs;
        int          rsps;
        int          sent;
        int          base;
        int          cyc;
        int          sel;
        logic [11:0] got[$];

        Rst = 1'b1; Cmd_Valid = 1'b0; Cmd_Op = 2'd0; Cmd_RA = 3'd0; Cmd_Data = 12'd0;
        Rsp_Ready = 1'b0; SSP_DO = 12'd0;

        // reset: outputs quiet and not ready while held
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_ready", 32'(Cmd_Ready), 32'd0);
        end
        check("rst_rsp", 32'({Rsp_Valid, Rsp_Data, Rsp_Err}), 32'd0);
        check("rst_ssp", 32'({SSP_SSEL, SSP_RA, SSP_WnR, SSP_EOC, SSP_DI, Busy}), 32'd0);
        Rst = 1'b0;
        step();
        check("ready_after_rst", 32'(Cmd_Ready), 32'd1);

        lat_test(2'b00, 3'd0, 12'hDED, 12'h000, 12'hDED);
        lat_test(2'b01, 3'd3, 12'h777, 12'h5A3, 12'h5A3);

        // back-pressure: five in flight, sixth waits for the first response
        Rsp_Ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            Cmd_Valid = 1'b1; Cmd_Op = 2'b00; Cmd_RA = 3'd2; Cmd_Data = 12'h0F1 + 12'(i);
            check("bp_ready", 32'(Cmd_Ready), 32'(i < 5));
            if (i < 5) step();
        end
        step(); step();
        check("bp_ready_held", 32'(Cmd_Ready), 32'd0);
        Rsp_Ready = 1'b1;
        acc6 = -1;
        for (int c = 0; c < 300 && got.size() < 6; c++) begin
            if (Rsp_Valid) got.push_back(Rsp_Data);
            rdy = Cmd_Ready;
            step();
            if (Cmd_Valid && rdy) begin
                Cmd_Valid = 1'b0;
                acc6 = got.size();
            end
        end
        Cmd_Valid = 1'b0;
        Rsp_Ready = 1'b0;
        check("bp_sixth_after_first", 32'(acc6), 32'd1);
        check("bp_count", 32'(got.size()), 32'd6);
        for (int j = 0; j < got.size(); j++) check("bp_order", 32'(got[j]), 32'h0F1 + 32'(j));
        step();

        poll_test(12'h004, 3, 3, 1'b0);
        poll_test(12'h800, 0, PT + 1, 1'b1);
        poll_test(12'h000, 0, 1, 1'b0);

        // reserved op: error response with no SSP access
        Rsp_Ready = 1'b0;
        push_cmd(2'b11, 3'd4, 12'hABC);
        eocs = 0;
        for (int c = 0; c < 50 && !Rsp_Valid; c++) begin
            if (SSP_EOC) eocs++;
            step();
        end
        check("rsv_eocs", 32'(eocs), 32'd0);
        check("rsv_valid", 32'(Rsp_Valid), 32'd1);
        check("rsv_data", 32'(Rsp_Data), 32'd0);
        check("rsv_err", 32'(Rsp_Err), 32'd1);
        consume();
        step();

        // reset while the first of three commands is in SETUP
        Cmd_Valid = 1'b1; Cmd_Op = 2'b00; Cmd_RA = 3'd0; Cmd_Data = 12'h111;
        step();
        Cmd_Data = 12'h222;
        step();
        Cmd_Data = 12'h333;
        step();
        Cmd_Valid = 1'b0;
        check("mid_in_setup", 32'({SSP_SSEL, SSP_EOC}), 32'b10);
        Rst = 1'b1;
        step();
        check("mid_ssel_drop", 32'({SSP_SSEL, SSP_EOC}), 32'd0);
        step();
        Rst = 1'b0;
        Rsp_Ready = 1'b1;
        eocs = 0; rsps = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (SSP_EOC) eocs++;
            if (Rsp_Valid) rsps++;
        end
        Rsp_Ready = 1'b0;
        check("mid_no_eoc", 32'(eocs), 32'd0);
        check("mid_no_rsp", 32'(rsps), 32'd0);
        check("mid_busy", 32'(Busy), 32'd0);
        check("mid_ready", 32'(Cmd_Ready), 32'd1);

        // randomized traffic scored by the monitor model
        sent = 0; base = rsp_cnt; cyc = 0;
        while ((sent < N_RAND || (rsp_cnt - base) < N_RAND) && cyc < 20000) begin
            if (!Cmd_Valid && sent < N_RAND && $urandom_range(3, 0) != 0) begin
                sel = $urandom_range(9, 0);
                Cmd_Op   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
                Cmd_RA   = 3'($urandom_range(4, 0));
                Cmd_Data = (Cmd_Op == 2'b10) ? (12'd1 << $urandom_range(11, 0)) : 12'($urandom);
                Cmd_Valid = 1'b1;
            end
            Rsp_Ready = 1'($urandom_range(1, 0));
            SSP_DO = 12'($urandom);
            rdy = Cmd_Ready;
            step();
            cyc++;
            if (Cmd_Valid && rdy) begin
                sent++;
                Cmd_Valid = 1'b0;
            end
        end
        Rsp_Ready = 1'b0;
        check("rand_sent", 32'(sent), 32'(N_RAND));
        check("rand_rsp_count", 32'(rsp_cnt - base), 32'(N_RAND));
        check("rand_busy_idle", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
